// File: rtl/ps2_key_sender.sv
// PS/2 device-side key sender: buffers {brk,code} commands in a small FIFO and
// serialises them as PS/2 frames, prefixing break codes with an F0 frame.
module ps2_key_sender #(
    parameter int CLK_HALF = 8,
    parameter int GAP      = 16,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] key_code,
    input  logic       key_brk,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0]  HALF_C     = 9'(CLK_HALF);
    localparam logic [8:0]  BIT_LAST_C = 9'(2 * CLK_HALF - 1);
    localparam logic [8:0]  DONE_CNT_C = 9'(2 * CLK_HALF - 2);
    localparam logic [8:0]  GAP_LAST_C = 9'(GAP - 1);
    localparam logic [AW:0] DEPTH_C    = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_C      = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    // Frame bit order: start, data LSB first, odd parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic r;
        case (idx)
            4'd0:    r = 1'b0;
            4'd1:    r = b[0];
            4'd2:    r = b[1];
            4'd3:    r = b[2];
            4'd4:    r = b[3];
            4'd5:    r = b[4];
            4'd6:    r = b[5];
            4'd7:    r = b[6];
            4'd8:    r = b[7];
            4'd9:    r = odd_parity(b);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    state_t        state_r, state_s;
    logic [8:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   count_r, count_nxt_s;
    logic [7:0]    byte_r, byte_s;
    logic [7:0]    pend_code_r, pend_code_s;
    logic          pend_valid_r, pend_valid_s;
    logic [8:0]    cnt_r, cnt_s;
    logic [3:0]    bit_r, bit_s;
    logic          ps2_clk_r, ps2_clk_s;
    logic          ps2_data_r, ps2_data_s;
    logic          frame_done_r, done_s;
    logic          busy_r, busy_s;
    logic          key_ready_r, key_ready_s;
    logic          push_s, pop_s;
    logic [8:0]    head_s;

    assign push_s     = key_valid & key_ready_r;
    assign pop_s      = (state_r == ST_LOAD);
    assign head_s     = mem_r[rd_ptr_r];
    assign key_ready  = key_ready_r;
    assign ps2_clk    = ps2_clk_r;
    assign ps2_data   = ps2_data_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {key_brk, key_code};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r <= count_nxt_s;
        end
    end

    // Next-state and next-output logic; line values are computed one cycle ahead.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        bit_s        = bit_r;
        byte_s       = byte_r;
        pend_code_s  = pend_code_r;
        pend_valid_s = pend_valid_r;
        done_s       = 1'b0;
        ps2_clk_s    = 1'b1;
        ps2_data_s   = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (count_r != '0) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (head_s[8]) begin
                    byte_s       = 8'hF0;
                    pend_code_s  = head_s[7:0];
                    pend_valid_s = 1'b1;
                end else begin
                    byte_s       = head_s[7:0];
                    pend_valid_s = 1'b0;
                end
                state_s    = ST_SHIFT;
                cnt_s      = 9'd0;
                bit_s      = 4'd0;
                ps2_data_s = 1'b0;
            end
            ST_SHIFT: begin
                if (cnt_r == BIT_LAST_C) begin
                    cnt_s = 9'd0;
                    if (bit_r == 4'd10) begin
                        state_s = ST_GAP;
                        bit_s   = 4'd0;
                    end else begin
                        bit_s      = 4'(bit_r + 4'd1);
                        ps2_data_s = frame_bit(byte_r, 4'(bit_r + 4'd1));
                    end
                end else begin
                    cnt_s      = cnt_r + 9'd1;
                    ps2_data_s = frame_bit(byte_r, bit_r);
                    ps2_clk_s  = (cnt_s < HALF_C);
                    done_s     = (bit_r == 4'd10) && (cnt_r == DONE_CNT_C);
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST_C) begin
                    cnt_s = 9'd0;
                    if (pend_valid_r) begin
                        byte_s       = pend_code_r;
                        pend_valid_s = 1'b0;
                        state_s      = ST_SHIFT;
                        bit_s        = 4'd0;
                        ps2_data_s   = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + 9'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 9'd0;
                bit_s   = 4'd0;
            end
        endcase
        busy_s      = !((state_s == ST_IDLE) && (count_nxt_s == '0));
        key_ready_s = (count_nxt_s != DEPTH_C);
    end

    // State, frame registers and registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 9'd0;
            bit_r        <= 4'd0;
            byte_r       <= 8'h00;
            pend_code_r  <= 8'h00;
            pend_valid_r <= 1'b0;
            ps2_clk_r    <= 1'b1;
            ps2_data_r   <= 1'b1;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
            key_ready_r  <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            bit_r        <= bit_s;
            byte_r       <= byte_s;
            pend_code_r  <= pend_code_s;
            pend_valid_r <= pend_valid_s;
            ps2_clk_r    <= ps2_clk_s;
            ps2_data_r   <= ps2_data_s;
            frame_done_r <= done_s;
            busy_r       <= busy_s;
            key_ready_r  <= key_ready_s;
        end
    end

endmodule

// File: tb/tb_ps2_key_sender.sv
// Bench for ps2_key_sender: three instances (CLK_HALF 8, 2, 255) watched by a
// falling-edge PS/2 receiver model; expected bytes come from the command stream.
module tb_ps2_key_sender;

    logic            clk = 1'b0;
    logic            clrn;
    logic [2:0]      kv, kb;
    logic [2:0][7:0] kc;
    logic [2:0]      kr, pc, pd, busyv, fd;

    always #5 clk = ~clk;

    ps2_key_sender #(.CLK_HALF(8), .GAP(16), .DEPTH(4)) u0 (
        .clk(clk), .clrn(clrn), .key_code(kc[0]), .key_brk(kb[0]), .key_valid(kv[0]),
        .key_ready(kr[0]), .ps2_clk(pc[0]), .ps2_data(pd[0]), .busy(busyv[0]), .frame_done(fd[0]));
    ps2_key_sender #(.CLK_HALF(2), .GAP(3), .DEPTH(4)) u1 (
        .clk(clk), .clrn(clrn), .key_code(kc[1]), .key_brk(kb[1]), .key_valid(kv[1]),
        .key_ready(kr[1]), .ps2_clk(pc[1]), .ps2_data(pd[1]), .busy(busyv[1]), .frame_done(fd[1]));
    ps2_key_sender #(.CLK_HALF(255), .GAP(1), .DEPTH(2)) u2 (
        .clk(clk), .clrn(clrn), .key_code(kc[2]), .key_brk(kb[2]), .key_valid(kv[2]),
        .key_ready(kr[2]), .ps2_clk(pc[2]), .ps2_data(pd[2]), .busy(busyv[2]), .frame_done(fd[2]));

    int n_cmp = 0;
    int n_bad = 0;

    // Receiver model state, one slot per instance.
    int          tick = 0;
    int          ch_of [3] = '{8, 2, 255};
    int          nb [3] = '{default: 0};
    int          last_fall [3] = '{default: 0};
    int          sp_err [3] = '{default: 0};
    int          fr_err [3] = '{default: 0};
    int          rx_n [3] = '{default: 0};
    int          fd_cnt [3] = '{default: 0};
    logic [2:0]  prev_c = 3'b111;
    logic [10:0] sh [3];
    logic [7:0]  rx_byte [3][64];
    logic [10:0] rx_raw [3][64];

    // Sample each bit on ps2_clk falling edges and assemble 11-bit frames.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!clrn) begin
                nb[i] = 0;
                prev_c[i] = 1'b1;
            end else begin
                if (fd[i]) fd_cnt[i]++;
                if (prev_c[i] && !pc[i]) begin
                    if (nb[i] > 0 && (tick - last_fall[i]) != 2 * ch_of[i]) sp_err[i]++;
                    last_fall[i] = tick;
                    sh[i][nb[i]] = pd[i];
                    nb[i]++;
                    if (nb[i] == 11) begin
                        if (sh[i][0] !== 1'b0 || sh[i][10] !== 1'b1 || (^sh[i][9:1]) !== 1'b1)
                            fr_err[i]++;
                        if (rx_n[i] < 64) begin
                            rx_byte[i][rx_n[i]] = sh[i][8:1];
                            rx_raw[i][rx_n[i]] = sh[i];
                        end
                        rx_n[i]++;
                        nb[i] = 0;
                    end
                end
                prev_c[i] = pc[i];
            end
        end
        tick++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input logic brk, input logic [7:0] code);
        int w;
        w = 0;
        @(negedge clk);
        while (!kr[i] && w < 4000) begin
            @(negedge clk);
            w++;
        end
        chk("push_ready_wait", 32'(w < 4000), 32'd1);
        kv[i] = 1'b1;
        kb[i] = brk;
        kc[i] = code;
        @(negedge clk);
        kv[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int bound);
        int w;
        w = 0;
        while (busyv[i] && w < bound) begin
            @(negedge clk);
            w++;
        end
        chk("idle_timeout", 32'(w < bound), 32'd1);
    endtask

    typedef struct {
        logic        brk;
        logic [7:0]  code;
        int          nfr;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [10:0] raw0;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] exp_q [$];

    initial begin
        int base, fbase, len, gap, w;
        logic [7:0] code_v;
        logic       brk_v;

        vecs[0] = '{1'b0, 8'h1C, 1, 8'h1C, 8'h00, 11'h438};
        vecs[1] = '{1'b1, 8'h1C, 2, 8'hF0, 8'h1C, 11'h7E0};
        vecs[2] = '{1'b0, 8'h00, 1, 8'h00, 8'h00, 11'h600};
        vecs[3] = '{1'b0, 8'hFF, 1, 8'hFF, 8'h00, 11'h7FE};
        vecs[4] = '{1'b0, 8'hF0, 1, 8'hF0, 8'h00, 11'h7E0};
        vecs[5] = '{1'b1, 8'hE0, 2, 8'hF0, 8'hE0, 11'h7E0};
        vecs[6] = '{1'b0, 8'h80, 1, 8'h80, 8'h00, 11'h500};

        clrn = 1'b0;
        kv = 3'b000;
        kb = 3'b000;
        kc = '0;
        repeat (3) @(negedge clk);
        chk("rst_key_ready", 32'(kr), 32'h7);
        chk("rst_busy", 32'(busyv), 32'h0);
        chk("rst_ps2_clk", 32'(pc), 32'h7);
        chk("rst_ps2_data", 32'(pd), 32'h7);
        chk("rst_frame_done", 32'(fd), 32'h0);
        clrn = 1'b1;

        // Start-bit latency and exact frame length.
        push(0, 1'b0, 8'h1C);
        @(negedge clk);
        chk("lat_t1_data", 32'(pd[0]), 32'd1);
        @(negedge clk);
        chk("lat_t2_start", 32'(pd[0]), 32'd0);
        len = 1;
        w = 0;
        while (!fd[0] && w < 1000) begin
            @(negedge clk);
            len++;
            w++;
        end
        chk("frame_len", 32'(len), 32'd176);
        wait_idle(0, 500);

        // Break: idle-high gap between F0 and code frames.
        push(0, 1'b1, 8'h1C);
        w = 0;
        while (!fd[0] && w < 1000) begin
            @(negedge clk);
            w++;
        end
        gap = 0;
        w = 0;
        @(negedge clk);
        while (pd[0] && w < 100) begin
            if (pc[0]) gap++;
            @(negedge clk);
            w++;
        end
        chk("gap_len", 32'(gap), 32'd16);
        len = 1;
        w = 0;
        while (!fd[0] && w < 1000) begin
            @(negedge clk);
            len++;
            w++;
        end
        chk("frame2_len", 32'(len), 32'd176);
        wait_idle(0, 500);

        // Single-command table.
        for (int v = 0; v < 7; v++) begin
            base = rx_n[0];
            fbase = fd_cnt[0];
            push(0, vecs[v].brk, vecs[v].code);
            wait_idle(0, 2000);
            chk("tbl_nframes", 32'(rx_n[0] - base), 32'(vecs[v].nfr));
            chk("tbl_frame_done", 32'(fd_cnt[0] - fbase), 32'(vecs[v].nfr));
            chk("tbl_byte0", 32'(rx_byte[0][base]), 32'(vecs[v].b0));
            chk("tbl_raw0", 32'(rx_raw[0][base]), 32'(vecs[v].raw0));
            if (vecs[v].nfr == 2) chk("tbl_byte1", 32'(rx_byte[0][base + 1]), 32'(vecs[v].b1));
        end

        // Six back-to-back pushes: five accepted, sixth dropped.
        base = rx_n[0];
        fbase = fd_cnt[0];
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("fifo_ready", 32'(kr[0]), 32'(k < 5));
            kv[0] = 1'b1;
            kb[0] = 1'b0;
            kc[0] = 8'h11 + 8'(k);
        end
        @(negedge clk);
        kv[0] = 1'b0;
        chk("fifo_full_hold", 32'(kr[0]), 32'd0);
        wait_idle(0, 3000);
        chk("fifo_nframes", 32'(rx_n[0] - base), 32'd5);
        chk("fifo_frame_done", 32'(fd_cnt[0] - fbase), 32'd5);
        for (int j = 0; j < 5; j++) chk("fifo_order", 32'(rx_byte[0][base + j]), 32'(8'h11 + 8'(j)));

        // Asynchronous reset during bit 4 with commands still queued.
        push(0, 1'b0, 8'h5A);
        push(0, 1'b0, 8'h21);
        push(0, 1'b0, 8'h22);
        w = 0;
        while (nb[0] < 4 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("rst_reach_bit4", 32'(w < 1000), 32'd1);
        repeat (10) @(negedge clk);
        base = rx_n[0];
        fbase = fd_cnt[0];
        #2 clrn = 1'b0;
        #1;
        chk("mid_rst_ps2_clk", 32'(pc[0]), 32'd1);
        chk("mid_rst_ps2_data", 32'(pd[0]), 32'd1);
        chk("mid_rst_busy", 32'(busyv[0]), 32'd0);
        chk("mid_rst_key_ready", 32'(kr[0]), 32'd1);
        chk("mid_rst_frame_done", 32'(fd[0]), 32'd0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_rst_busy", 32'(busyv[0]), 32'd0);
        chk("post_rst_frames", 32'(rx_n[0] - base), 32'd0);
        chk("post_rst_frame_done", 32'(fd_cnt[0] - fbase), 32'd0);
        push(0, 1'b0, 8'h33);
        wait_idle(0, 1000);
        chk("post_rst_nframes", 32'(rx_n[0] - base), 32'd1);
        chk("post_rst_byte", 32'(rx_byte[0][base]), 32'h33);
        chk("post_rst_raw", 32'(rx_raw[0][base]), 32'h666);

        // Randomised command stream at CLK_HALF=2.
        for (int r = 0; r < 30; r++) begin
            repeat ($urandom_range(0, 25)) @(negedge clk);
            brk_v = 1'($urandom_range(0, 1));
            code_v = 8'($urandom_range(0, 255));
            push(1, brk_v, code_v);
            if (brk_v) exp_q.push_back(8'hF0);
            exp_q.push_back(code_v);
        end
        wait_idle(1, 3000);
        chk("rand_nframes", 32'(rx_n[1]), 32'(exp_q.size()));
        chk("rand_frame_done", 32'(fd_cnt[1]), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < 64; j++) chk("rand_byte", 32'(rx_byte[1][j]), 32'(exp_q[j]));

        // Break at CLK_HALF=255.
        push(2, 1'b1, 8'h3A);
        wait_idle(2, 20000);
        chk("slow_nframes", 32'(rx_n[2]), 32'd2);
        chk("slow_frame_done", 32'(fd_cnt[2]), 32'd2);
        chk("slow_byte0", 32'(rx_byte[2][0]), 32'hF0);
        chk("slow_byte1", 32'(rx_byte[2][1]), 32'h3A);

        for (int i = 0; i < 3; i++) begin
            chk("rx_frame_errors", 32'(fr_err[i]), 32'd0);
            chk("rx_clk_spacing_errors", 32'(sp_err[i]), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
